bus_master_seq: RTL and testbench
=================================

// Module: bus_master_seq
// PURPOSE
//  Alternate 68030 bus master for DMA-capable peripherals. Takes single-transfer requests on a simple valid/ready port.
//  Acquires the CPU bus via nBR/nBG/nBGACK and runs one asynchronous 68030 bus cycle (nAS/nDS, RnW, SIZ, FC).
//  Completes on nDSACK/nSTERM/nBERR, then releases the bus. It initiates cycles that the system controller decodes and terminates.
// PARAMETERS
//  TIMEOUT_CYC  256  DRAM_CLK cycles in WAIT before self-abort (backstop behind the system BERR timer)
//  SYNC_STAGES  2    synchroniser depth on nBG, nAS_in, nBGACK_in, nDSACK, nSTERM, nBERR
// PORTS
//  DRAM_CLK     in   1   50MHz clock; all logic clocks on its rising edge
//  nRST         in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; a transfer is accepted on valid&&ready
//  req_addr     in   32  byte address
//  req_wr       in   1   1=write, 0=read
//  req_siz      in   2   68030 SIZ encoding (01 byte, 10 word, 11 3-byte, 00 long)
//  req_fc       in   3   function code driven on FC
//  req_wdata    in   32  write data, already lane-aligned by the requester
//  rsp_valid    out  1   one-cycle pulse on completion
//  rsp_status   out  2   00 ok, 01 BERR, 10 port narrower than SIZ, 11 timeout
//  rsp_rdata    out  32  read data latched at termination (valid with rsp_valid)
//  nBR          out  1   bus request
//  nBG          in   1   bus grant
//  nBGACK_in    in   1   other master's grant acknowledge
//  nBGACK       out  1   grant acknowledge; low for the whole tenure
//  nAS_in       in   1   bus address strobe, observed
//  bus_oe       out  1   enables ADDR/FC/SIZ/RnW/nAS/nDS drivers
//  ADDR_O       out  32  address;  FC_O out 3;  SIZ_O out 2;  RnW_O out 1
//  nAS_O        out  1   address strobe
//  nDS_O        out  1   data strobe
//  D_O          out  32  write data;  D_OE out 1 (data bus drive enable);  D_I in 32 (read data)
//  nDSACK       in   2   async termination / port size (00 long, 01 word, 10 byte)
//  nSTERM       in   1   synchronous termination (32-bit port)
//  nBERR        in   1   bus error
// BEHAVIOUR
//  Reset (async): nBR=nBGACK=nAS_O=nDS_O=1, RnW_O=1, bus_oe=D_OE=0, rsp_valid=0, rsp_status=00, rsp_rdata=0, state=IDLE.
//  Reset mid-tenure releases all drivers immediately; no response is issued.
//  States:
//   IDLE: req_ready=1. On accept, latch addr/wr/siz/fc/wdata; nBR=0; go to ARB.
//   ARB: wait for synced nBG=0 && nAS_in=1 && nBGACK_in=1, all seen on the same edge. Then nBGACK=0, nBR=1, bus_oe=1,
//    drive ADDR/FC/SIZ/RnW; go to ADDR.
//   ADDR: one cycle of address setup. For writes, D_OE=1.
//   STRB: nAS_O=0. For reads, nDS_O=0 in the same cycle; for writes, nDS_O=0 one cycle later. Then go to WAIT.
//   WAIT: increment the timeout counter each cycle.
//    Precedence: BERR > STERM > DSACK > timeout.
//    nBERR=0 -> status 01. nSTERM=0 -> 00. nDSACK!=11 -> 00, or 10 if the acked port width is narrower than the bytes
//    SIZ requires (e.g. byte port with word SIZ). Counter reaching TIMEOUT_CYC-1 -> 11.
//    On any of these, latch D_I on reads (00 only; otherwise rdata=0); go to TERM.
//   TERM: nAS_O=nDS_O=1, D_OE=0, rsp_valid=1 for this cycle only; go to REL.
//   REL: bus_oe=0 with strobes still high, nBGACK=1; go to IDLE.
//  Exactly one bus cycle per tenure; no dynamic-sizing retries (status 10 is reported, never split).
//  Requester holds req_* only until accept; the block never depends on them afterwards.
//  nBG deasserted during ARB: stay in ARB with nBR held low.
//  nBG deasserted after nBGACK is asserted: ignored; the tenure completes.
//  Timeout counter is 8 bits (clog2(TIMEOUT_CYC)); it clears on WAIT entry and never wraps.
//  nDSACK/nSTERM/nBERR are only sampled in WAIT; assertions in other states are ignored.
//  Latency, uncontended read with immediate ack: accept -> rsp_valid = ARB(>=SYNC_STAGES+1)+ADDR+STRB+WAIT(SYNC_STAGES)+1.
// STRUCTURE
//  Shared package pg68k_bus_pkg holds FC space codes, SIZ codes, DSACK port-size codes and rsp_status codes.
//  Sub-module bus_sync (parameterised N-bit SYNC_STAGES flop synchroniser, reset to all-ones) is instantiated for
//  the bus inputs.
//  Top level contains the one-hot FSM, the request latch and the timeout counter.
// TESTING
//  Read from 0xFFF00004, FC=101, SIZ=00, responder nDSACK=00 with D=0xDEADBEEF -> one rsp_valid, status 00, rdata 0xDEADBEEF,
//   nBGACK high afterwards.
//  Byte write 0xA5 to 0xFFE00010; responder acks nDSACK=10 -> nDS_O falls 1 cycle after nAS_O, D_OE covers nDS_O low, status 00.
//  Word read with nDSACK=10 (byte port) -> status 10, rdata 0; nAS_O has no second assertion.
//  Hold nAS_in low 20 cycles after nBG=0 -> no bus drive until nAS_in is sampled high.
//  No ack for TIMEOUT_CYC cycles -> status 11; nBERR and nSTERM asserted together -> status 01.
//  nRST pulsed in WAIT -> bus_oe=0, nAS_O=1, nBGACK=1 asynchronously; no rsp_valid; next request runs normally.

Source files
------------

// File: rtl/pg68k_bus_pkg.sv
// Shared 68030 bus encodings: function codes, SIZ, DSACK port sizes and response status,
// plus helpers for comparing transfer size against the acknowledged port width.
package pg68k_bus_pkg;

    localparam logic [2:0] FC_USER_DATA = 3'b001;
    localparam logic [2:0] FC_USER_PROG = 3'b010;
    localparam logic [2:0] FC_SUPV_DATA = 3'b101;
    localparam logic [2:0] FC_SUPV_PROG = 3'b110;
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    localparam logic [1:0] DSACK_LONG = 2'b00;
    localparam logic [1:0] DSACK_WORD = 2'b01;
    localparam logic [1:0] DSACK_BYTE = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_BERR    = 2'b01;
    localparam logic [1:0] RSP_NARROW  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    function automatic logic [2:0] sizBytes(input logic [1:0] siz);
        logic [2:0] n;
        case (siz)
            SIZ_BYTE:  n = 3'd1;
            SIZ_WORD:  n = 3'd2;
            SIZ_3BYTE: n = 3'd3;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] portBytes(input logic [1:0] dsack);
        logic [2:0] n;
        case (dsack)
            DSACK_LONG: n = 3'd4;
            DSACK_WORD: n = 3'd2;
            default:    n = 3'd1;
        endcase
        return n;
    endfunction

    // True when the acknowledging port cannot carry every byte the SIZ code asked for.
    function automatic logic portNarrow(input logic [1:0] dsack, input logic [1:0] siz);
        return portBytes(dsack) < sizBytes(siz);
    endfunction

endpackage

// File: rtl/bus_sync.sv
// N-bit multi-flop synchroniser for asynchronous bus inputs; idles at all-ones (negated strobes).
module bus_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             DRAM_CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < STAGES; gi++) begin : gStage
        logic [WIDTH-1:0] stageReg;
        if (gi == 0) begin : gFirst
            always_ff @(posedge DRAM_CLK or negedge nRST) begin
                if (!nRST) stageReg <= '1;
                else       stageReg <= d;
            end
        end else begin : gNext
            always_ff @(posedge DRAM_CLK or negedge nRST) begin
                if (!nRST) stageReg <= '1;
                else       stageReg <= gStage[gi-1].stageReg;
            end
        end
    end

    assign q = gStage[STAGES-1].stageReg;

endmodule

// File: rtl/bus_master_seq.sv
// Alternate 68030 bus master: arbitrates for the bus, runs exactly one asynchronous bus cycle
// per request, reports the termination status and releases the bus.
module bus_master_seq
    import pg68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        DRAM_CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_siz,
    input  logic [2:0]  req_fc,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic        nBR,
    input  logic        nBG,
    input  logic        nBGACK_in,
    output logic        nBGACK,
    input  logic        nAS_in,
    output logic        bus_oe,
    output logic [31:0] ADDR_O,
    output logic [2:0]  FC_O,
    output logic [1:0]  SIZ_O,
    output logic        RnW_O,
    output logic        nAS_O,
    output logic        nDS_O,
    output logic [31:0] D_O,
    output logic        D_OE,
    input  logic [31:0] D_I,
    input  logic [1:0]  nDSACK,
    input  logic        nSTERM,
    input  logic        nBERR
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [6:0] {
        S_IDLE = 7'b000_0001,
        S_ARB  = 7'b000_0010,
        S_ADDR = 7'b000_0100,
        S_STRB = 7'b000_1000,
        S_WAIT = 7'b001_0000,
        S_TERM = 7'b010_0000,
        S_REL  = 7'b100_0000
    } state_e;

    state_e          stateReg, stateNext;
    logic [31:0]     addrReg, wdataReg, rdataReg;
    logic            wrReg;
    logic [1:0]      sizReg, statusReg;
    logic [2:0]      fcReg;
    logic [CW-1:0]   cntReg;

    logic [6:0]      syncIn, syncOut;
    logic            bgS, asS, bgackS, stermS, berrS;
    logic [1:0]      dsackS;
    logic            reqAccept, termHit;
    logic [1:0]      termStatus;

    assign syncIn = {nBG, nAS_in, nBGACK_in, nDSACK, nSTERM, nBERR};

    bus_sync #(
        .WIDTH  (7),
        .STAGES (SYNC_STAGES)
    ) uSync (
        .DRAM_CLK (DRAM_CLK),
        .nRST     (nRST),
        .d        (syncIn),
        .q        (syncOut)
    );

    assign {bgS, asS, bgackS, dsackS, stermS, berrS} = syncOut;
    assign reqAccept = req_valid && (stateReg == S_IDLE);

    always_comb begin
        stateNext  = stateReg;
        termHit    = 1'b0;
        termStatus = RSP_OK;
        case (stateReg)
            S_IDLE: if (req_valid) stateNext = S_ARB;
            // Grant, idle address strobe and no other owner must all be seen together.
            S_ARB:  if (!bgS && asS && bgackS) stateNext = S_ADDR;
            S_ADDR: stateNext = S_STRB;
            S_STRB: stateNext = S_WAIT;
            S_WAIT: begin
                if (!berrS) begin
                    termHit    = 1'b1;
                    termStatus = RSP_BERR;
                end else if (!stermS) begin
                    termHit    = 1'b1;
                    termStatus = RSP_OK;
                end else if (dsackS != DSACK_NONE) begin
                    termHit    = 1'b1;
                    termStatus = portNarrow(dsackS, sizReg) ? RSP_NARROW : RSP_OK;
                end else if (cntReg == CNT_LAST) begin
                    termHit    = 1'b1;
                    termStatus = RSP_TIMEOUT;
                end
                if (termHit) stateNext = S_TERM;
            end
            S_TERM: stateNext = S_REL;
            S_REL:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge DRAM_CLK or negedge nRST) begin
        if (!nRST) begin
            stateReg  <= S_IDLE;
            addrReg   <= '0;
            wdataReg  <= '0;
            wrReg     <= 1'b0;
            sizReg    <= SIZ_LONG;
            fcReg     <= '0;
            cntReg    <= '0;
            statusReg <= RSP_OK;
            rdataReg  <= '0;
        end else begin
            stateReg <= stateNext;
            if (reqAccept) begin
                addrReg  <= req_addr;
                wdataReg <= req_wdata;
                wrReg    <= req_wr;
                sizReg   <= req_siz;
                fcReg    <= req_fc;
            end
            // Counter is zeroed on the way into WAIT and saturates rather than wrapping.
            if (stateReg == S_STRB) begin
                cntReg <= '0;
            end else if (stateReg == S_WAIT && cntReg != CNT_LAST) begin
                cntReg <= cntReg + CW'(1);
            end
            if (termHit) begin
                statusReg <= termStatus;
                rdataReg  <= (!wrReg && termStatus == RSP_OK) ? D_I : 32'h0;
            end
        end
    end

    // All bus outputs decode straight from state so an asynchronous reset frees the bus at once.
    assign req_ready  = (stateReg == S_IDLE);
    assign nBR        = ~(stateReg == S_ARB);
    assign bus_oe     = (stateReg == S_ADDR) || (stateReg == S_STRB) ||
                        (stateReg == S_WAIT) || (stateReg == S_TERM);
    assign nBGACK     = ~bus_oe;
    assign nAS_O      = ~((stateReg == S_STRB) || (stateReg == S_WAIT));
    assign nDS_O      = ~(((stateReg == S_STRB) && !wrReg) || (stateReg == S_WAIT));
    assign D_OE       = wrReg && ((stateReg == S_ADDR) || (stateReg == S_STRB) ||
                                  (stateReg == S_WAIT));
    assign rsp_valid  = (stateReg == S_TERM);
    assign rsp_status = statusReg;
    assign rsp_rdata  = rdataReg;
    assign ADDR_O     = addrReg;
    assign FC_O       = fcReg;
    assign SIZ_O      = sizReg;
    assign RnW_O      = ~wrReg;
    assign D_O        = wdataReg;

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq: a simple arbiter/responder is played from one initial block.
`define CHK(tag, obs, exp) \
    begin \
        nCmp++; \
        assert ((obs) === (exp)) else begin \
            nBad++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_bus_master_seq;

    logic        DRAM_CLK = 1'b0;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [1:0]  req_siz;
    logic [2:0]  req_fc;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        nBR;
    logic        nBG;
    logic        nBGACK_in;
    logic        nBGACK;
    logic        nAS_in;
    logic        bus_oe;
    logic [31:0] ADDR_O;
    logic [2:0]  FC_O;
    logic [1:0]  SIZ_O;
    logic        RnW_O;
    logic        nAS_O;
    logic        nDS_O;
    logic [31:0] D_O;
    logic        D_OE;
    logic [31:0] D_I;
    logic [1:0]  nDSACK;
    logic        nSTERM;
    logic        nBERR;

    int nCmp = 0;
    int nBad = 0;

    bus_master_seq dut (
        .DRAM_CLK   (DRAM_CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wr     (req_wr),
        .req_siz    (req_siz),
        .req_fc     (req_fc),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rsp_rdata  (rsp_rdata),
        .nBR        (nBR),
        .nBG        (nBG),
        .nBGACK_in  (nBGACK_in),
        .nBGACK     (nBGACK),
        .nAS_in     (nAS_in),
        .bus_oe     (bus_oe),
        .ADDR_O     (ADDR_O),
        .FC_O       (FC_O),
        .SIZ_O      (SIZ_O),
        .RnW_O      (RnW_O),
        .nAS_O      (nAS_O),
        .nDS_O      (nDS_O),
        .D_O        (D_O),
        .D_OE       (D_OE),
        .D_I        (D_I),
        .nDSACK     (nDSACK),
        .nSTERM     (nSTERM),
        .nBERR      (nBERR)
    );

    always #10 DRAM_CLK = ~DRAM_CLK;

    // Bus activity monitor, sampled on the falling edge.
    int   cyc = 0, asFalls = 0, rspCount = 0, asFallCyc = 0, dsFallCyc = 0, rspCyc = 0, doeBad = 0;
    logic prevAs = 1'b1, prevDs = 1'b1;
    always @(negedge DRAM_CLK) begin
        if (prevAs && !nAS_O) begin
            asFalls++;
            asFallCyc = cyc;
        end
        if (prevDs && !nDS_O) dsFallCyc = cyc;
        if (!nDS_O && !RnW_O && !D_OE) doeBad++;
        if (rsp_valid) begin
            rspCount++;
            rspCyc = cyc;
        end
        nCmp++;
        if (nBGACK !== ~bus_oe) begin
            nBad++;
            $error("FAIL mon_nBGACK_tracks_oe: nBGACK=%0b bus_oe=%0b at cyc %0d", nBGACK, bus_oe, cyc);
        end
        nCmp++;
        if (nAS_O === 1'b0 && bus_oe !== 1'b1) begin
            nBad++;
            $error("FAIL mon_as_without_oe: cyc %0d", cyc);
        end
        nCmp++;
        if (rsp_valid === 1'b1 && nAS_O !== 1'b1) begin
            nBad++;
            $error("FAIL mon_rsp_with_as: cyc %0d", cyc);
        end
        prevAs = nAS_O;
        prevDs = nDS_O;
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic startReq(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [2:0] f, input logic [31:0] d);
        @(negedge DRAM_CLK);
        `CHK("req_ready_idle", req_ready, 1'b1)
        req_addr = a; req_wr = w; req_siz = s; req_fc = f; req_wdata = d; req_valid = 1'b1;
        @(negedge DRAM_CLK);
        req_valid = 1'b0;
        req_addr = 32'h0; req_wr = 1'b0; req_siz = 2'b01; req_fc = 3'b000; req_wdata = 32'h0;
        `CHK("nBR_low_in_arb", nBR, 1'b0)
    endtask

    // Waits for nAS_O, captures the driven bus, applies the termination, waits for rsp_valid.
    task automatic respond(input logic [1:0] dsk, input logic st, input logic be, input logic [31:0] rd,
                           input int maxCyc, output logic done, output logic [1:0] stat,
                           output logic [31:0] rdat, output logic [31:0] addrSeen,
                           output logic [2:0] fcSeen, output logic [1:0] sizSeen,
                           output logic rnwSeen, output logic [31:0] dSeen);
        done = 1'b0; stat = 2'b00; rdat = 32'h0;
        for (int i = 0; i < maxCyc && !done; i++) begin
            @(negedge DRAM_CLK);
            if (!nAS_O) done = 1'b1;
        end
        addrSeen = ADDR_O; fcSeen = FC_O; sizSeen = SIZ_O; rnwSeen = RnW_O; dSeen = D_O;
        nBG = 1'b1;
        nDSACK = dsk; nSTERM = st; nBERR = be; D_I = rd;
        if (done) begin
            done = 1'b0;
            for (int i = 0; i < maxCyc && !done; i++) begin
                @(negedge DRAM_CLK);
                if (rsp_valid) begin
                    done = 1'b1;
                    stat = rsp_status;
                    rdat = rsp_rdata;
                end
            end
        end
        nDSACK = 2'b11; nSTERM = 1'b1; nBERR = 1'b1; D_I = 32'h0;
    endtask

    initial begin
        logic        done;
        logic [1:0]  stat, sizSeen;
        logic [31:0] rdat, addrSeen, dSeen;
        logic [2:0]  fcSeen;
        logic        rnwSeen;
        int          rsp0, as0, doe0;

        nRST = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wr = 1'b0; req_siz = 2'b00;
        req_fc = 3'b000; req_wdata = 32'h0; nBG = 1'b1; nBGACK_in = 1'b1; nAS_in = 1'b1;
        D_I = 32'h0; nDSACK = 2'b11; nSTERM = 1'b1; nBERR = 1'b1;

        // Reset state
        repeat (3) @(negedge DRAM_CLK);
        `CHK("rst_nBR", nBR, 1'b1)
        `CHK("rst_nBGACK", nBGACK, 1'b1)
        `CHK("rst_nAS_O", nAS_O, 1'b1)
        `CHK("rst_nDS_O", nDS_O, 1'b1)
        `CHK("rst_RnW_O", RnW_O, 1'b1)
        `CHK("rst_bus_oe", bus_oe, 1'b0)
        `CHK("rst_D_OE", D_OE, 1'b0)
        `CHK("rst_rsp_valid", rsp_valid, 1'b0)
        `CHK("rst_rsp_status", rsp_status, 2'b00)
        `CHK("rst_rsp_rdata", rsp_rdata, 32'h0)
        nRST = 1'b1;
        repeat (2) @(negedge DRAM_CLK);
        $display("step reset checked");

        // Long read, 32-bit port
        rsp0 = rspCount;
        startReq(32'hFFF00004, 1'b0, 2'b00, 3'b101, 32'h0);
        nBG = 1'b0;
        respond(2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("rd_done", done, 1'b1)
        `CHK("rd_addr", addrSeen, 32'hFFF00004)
        `CHK("rd_fc", fcSeen, 3'b101)
        `CHK("rd_siz", sizSeen, 2'b00)
        `CHK("rd_rnw", rnwSeen, 1'b1)
        `CHK("rd_status", stat, 2'b00)
        `CHK("rd_rdata", rdat, 32'hDEADBEEF)
        repeat (3) @(negedge DRAM_CLK);
        `CHK("rd_one_rsp", rspCount - rsp0, 1)
        `CHK("rd_nBGACK_after", nBGACK, 1'b1)
        `CHK("rd_bus_oe_after", bus_oe, 1'b0)
        $display("step long read status=%0h rdata=%08h", stat, rdat);

        // Byte write to a byte port
        rsp0 = rspCount; doe0 = doeBad;
        startReq(32'hFFE00010, 1'b1, 2'b01, 3'b001, 32'hA5000000);
        nBG = 1'b0;
        respond(2'b10, 1'b1, 1'b1, 32'h0, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("wr_done", done, 1'b1)
        `CHK("wr_addr", addrSeen, 32'hFFE00010)
        `CHK("wr_rnw", rnwSeen, 1'b0)
        `CHK("wr_data", dSeen, 32'hA5000000)
        `CHK("wr_status", stat, 2'b00)
        `CHK("wr_rdata", rdat, 32'h0)
        repeat (3) @(negedge DRAM_CLK);
        `CHK("wr_ds_lag", dsFallCyc - asFallCyc, 1)
        `CHK("wr_doe_covers_ds", doeBad - doe0, 0)
        `CHK("wr_one_rsp", rspCount - rsp0, 1)
        $display("step byte write status=%0h ds_lag=%0d", stat, dsFallCyc - asFallCyc);

        // Word read acked by a byte port
        as0 = asFalls;
        startReq(32'h00001000, 1'b0, 2'b10, 3'b001, 32'h0);
        nBG = 1'b0;
        respond(2'b10, 1'b1, 1'b1, 32'h12345678, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("narrow_done", done, 1'b1)
        `CHK("narrow_status", stat, 2'b10)
        `CHK("narrow_rdata", rdat, 32'h0)
        `CHK("rd_ds_lag0", dsFallCyc - asFallCyc, 0)
        repeat (6) @(negedge DRAM_CLK);
        `CHK("narrow_single_as", asFalls - as0, 1)
        $display("step narrow read status=%0h", stat);

        // Another master still holds nAS: no drive until it is seen high; grant withdrawn in ARB
        nAS_in = 1'b0;
        startReq(32'h00002000, 1'b0, 2'b00, 3'b010, 32'h0);
        nBG = 1'b0;
        repeat (20) @(negedge DRAM_CLK);
        `CHK("as_busy_bus_oe", bus_oe, 1'b0)
        `CHK("as_busy_nBGACK", nBGACK, 1'b1)
        nBG = 1'b1; nAS_in = 1'b1;
        repeat (6) @(negedge DRAM_CLK);
        `CHK("bg_drop_nBR", nBR, 1'b0)
        `CHK("bg_drop_bus_oe", bus_oe, 1'b0)
        nBG = 1'b0;
        respond(2'b00, 1'b1, 1'b1, 32'h0BADF00D, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("as_busy_done", done, 1'b1)
        `CHK("as_busy_rdata", rdat, 32'h0BADF00D)
        repeat (3) @(negedge DRAM_CLK);
        $display("step arbitration hold status=%0h", stat);

        // No termination at all: self timeout
        startReq(32'h00003000, 1'b0, 2'b00, 3'b001, 32'h0);
        nBG = 1'b0;
        respond(2'b11, 1'b1, 1'b1, 32'h55555555, 400, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("tmo_done", done, 1'b1)
        `CHK("tmo_status", stat, 2'b11)
        `CHK("tmo_rdata", rdat, 32'h0)
        repeat (3) @(negedge DRAM_CLK);
        `CHK("tmo_wait_len", rspCyc - asFallCyc, 257)
        $display("step timeout status=%0h cycles=%0d", stat, rspCyc - asFallCyc);

        // BERR and STERM together: BERR wins
        startReq(32'h00004000, 1'b0, 2'b00, 3'b001, 32'h0);
        nBG = 1'b0;
        respond(2'b11, 1'b0, 1'b0, 32'h77777777, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("berr_done", done, 1'b1)
        `CHK("berr_status", stat, 2'b01)
        `CHK("berr_rdata", rdat, 32'h0)
        repeat (3) @(negedge DRAM_CLK);
        $display("step berr status=%0h", stat);

        // STERM alone terminates a long read
        startReq(32'h00005000, 1'b0, 2'b00, 3'b101, 32'h0);
        nBG = 1'b0;
        respond(2'b11, 1'b0, 1'b1, 32'hCAFEF00D, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("sterm_status", stat, 2'b00)
        `CHK("sterm_rdata", rdat, 32'hCAFEF00D)
        repeat (3) @(negedge DRAM_CLK);
        $display("step sterm status=%0h rdata=%08h", stat, rdat);

        // Reset pulsed in WAIT
        rsp0 = rspCount;
        startReq(32'h00006000, 1'b0, 2'b00, 3'b001, 32'h0);
        nBG = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge DRAM_CLK);
            if (!nAS_O) done = 1'b1;
        end
        `CHK("rstw_reached_strobe", done, 1'b1)
        nBG = 1'b1;
        repeat (3) @(negedge DRAM_CLK);
        #5 nRST = 1'b0;
        #1;
        `CHK("rstw_bus_oe", bus_oe, 1'b0)
        `CHK("rstw_nAS_O", nAS_O, 1'b1)
        `CHK("rstw_nBGACK", nBGACK, 1'b1)
        @(negedge DRAM_CLK);
        nRST = 1'b1;
        repeat (4) @(negedge DRAM_CLK);
        `CHK("rstw_no_rsp", rspCount - rsp0, 0)
        startReq(32'h00007000, 1'b0, 2'b00, 3'b001, 32'h0);
        nBG = 1'b0;
        respond(2'b00, 1'b1, 1'b1, 32'h11223344, 50, done, stat, rdat, addrSeen, fcSeen, sizSeen, rnwSeen, dSeen);
        `CHK("rstw_next_status", stat, 2'b00)
        `CHK("rstw_next_rdata", rdat, 32'h11223344)
        repeat (3) @(negedge DRAM_CLK);
        `CHK("rstw_one_rsp", rspCount - rsp0, 1)
        $display("step reset-in-wait then read rdata=%08h", rdat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
